nonce_target_scanner: RTL and testbench

//  Post-processing reader for the per-nonce hash words that bitcoin_hash writes
//  to memory. On start, it reads NUM_NONCES consecutive 32-bit words from

---
 rtl/nonce_target_scanner.sv | 144 ++++++++++++++
 tb/tb_nonce_target_scanner.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_target_scanner.sv
// rtl/nonce_target_scanner.sv - scans per-nonce hash words against a target and writes a summary record
module nonce_target_scanner #(
    parameter int NUM_NONCES = 16,
    parameter int CW         = $clog2(NUM_NONCES + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [15:0]   hash_in_addr,
    input  logic [15:0]   result_addr,
    input  logic [31:0]   target,
    output logic          done,
    output logic          found,
    output logic [CW-1:0] hit_count,
    output logic [15:0]   best_nonce,
    output logic [31:0]   min_hash,
    output logic          mem_clk,
    output logic          mem_we,
    output logic [15:0]   memory_addr,
    output logic [31:0]   memory_write_data,
    input  logic [31:0]   memory_read_data
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_SUM, S_WRITE} state_t;

    state_t        r_state;
    logic          r_done;
    logic          r_found;
    logic [CW-1:0] r_hit_count;
    logic [15:0]   r_best_nonce;
    logic [31:0]   r_min_hash;
    logic          r_we;
    logic [15:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [15:0]   r_res_addr;
    logic [31:0]   r_target;
    logic [8:0]    r_cyc;
    logic [CW-1:0] r_wcnt;
    logic [31:0]   r_wmin;
    logic [15:0]   r_wbest;

    logic          w_capture;
    logic          w_last_cyc;
    logic          w_more;
    logic          w_hit;
    logic          w_less;
    logic [15:0]   w_word_idx;
    logic [7:0]    w_cnt8;

    // Read data lags the address by two edges, so READ cycle k captures word k-1.
    assign w_capture  = (r_cyc != 9'd0);
    assign w_last_cyc = (r_cyc == 9'(NUM_NONCES));
    assign w_more     = (r_cyc == 9'd0) || (r_cyc < 9'(NUM_NONCES - 1));
    assign w_hit      = (memory_read_data < r_target);
    assign w_less     = (memory_read_data < r_wmin);
    assign w_word_idx = 16'(r_cyc - 9'd1);
    assign w_cnt8     = 8'(r_wcnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_done       <= 1'b1;
            r_found      <= 1'b0;
            r_hit_count  <= '0;
            r_best_nonce <= 16'd0;
            r_min_hash   <= 32'hFFFF_FFFF;
            r_we         <= 1'b0;
            r_addr       <= 16'd0;
            r_wdata      <= 32'd0;
            r_res_addr   <= 16'd0;
            r_target     <= 32'd0;
            r_cyc        <= 9'd0;
            r_wcnt       <= '0;
            r_wmin       <= 32'hFFFF_FFFF;
            r_wbest      <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_res_addr <= result_addr;
                        r_target   <= target;
                        r_addr     <= hash_in_addr;
                        r_wcnt     <= '0;
                        r_wmin     <= 32'hFFFF_FFFF;
                        r_wbest    <= 16'd0;
                        r_cyc      <= 9'd0;
                        r_done     <= 1'b0;
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    if (w_more) begin
                        r_addr <= r_addr + 16'd1;
                    end
                    if (w_capture) begin
                        if (w_hit) begin
                            r_wcnt <= r_wcnt + CW'(1);
                        end
                        // Strict compare keeps the lowest index on ties.
                        if (w_less) begin
                            r_wmin  <= memory_read_data;
                            r_wbest <= w_word_idx;
                        end
                    end
                    if (w_last_cyc) begin
                        r_state <= S_SUM;
                    end
                    r_cyc <= r_cyc + 9'd1;
                end
                S_SUM: begin
                    r_we         <= 1'b1;
                    r_addr       <= r_res_addr;
                    r_wdata      <= {(r_wcnt != '0), 7'd0, w_cnt8, r_wbest};
                    r_found      <= (r_wcnt != '0);
                    r_hit_count  <= r_wcnt;
                    r_best_nonce <= r_wbest;
                    r_min_hash   <= r_wmin;
                    r_state      <= S_WRITE;
                end
                S_WRITE: begin
                    r_we    <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_we    <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign done              = r_done;
    assign found             = r_found;
    assign hit_count         = r_hit_count;
    assign best_nonce        = r_best_nonce;
    assign min_hash          = r_min_hash;
    assign mem_clk           = clk;
    assign mem_we            = r_we;
    assign memory_addr       = r_addr;
    assign memory_write_data = r_wdata;

endmodule

// File: tb/tb_nonce_target_scanner.sv
// tb/tb_nonce_target_scanner.sv - scoreboard bench for nonce_target_scanner
module tb_nonce_target_scanner;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic        found;
        logic [31:0] cnt;
        logic [15:0] best;
        logic [31:0] mn;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        start0, start1;
    logic [15:0] hash_in_addr, result_addr;
    logic [31:0] target;

    logic        done0, found0, mem_clk0, mem_we0;
    logic [4:0]  hit_count0;
    logic [15:0] best_nonce0, memory_addr0;
    logic [31:0] min_hash0, memory_write_data0, rdata0;

    logic        done1, found1, mem_clk1, mem_we1;
    logic [0:0]  hit_count1;
    logic [15:0] best_nonce1, memory_addr1;
    logic [31:0] min_hash1, memory_write_data1, rdata1;

    logic [31:0] mem0 [0:65535];
    logic [31:0] mem1 [0:65535];

    exp_t q0[$];
    exp_t q1[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_we0  = 0;

    nonce_target_scanner #(.NUM_NONCES(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0),
        .hash_in_addr(hash_in_addr), .result_addr(result_addr), .target(target),
        .done(done0), .found(found0), .hit_count(hit_count0),
        .best_nonce(best_nonce0), .min_hash(min_hash0),
        .mem_clk(mem_clk0), .mem_we(mem_we0), .memory_addr(memory_addr0),
        .memory_write_data(memory_write_data0), .memory_read_data(rdata0)
    );

    nonce_target_scanner #(.NUM_NONCES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1),
        .hash_in_addr(hash_in_addr), .result_addr(result_addr), .target(target),
        .done(done1), .found(found1), .hit_count(hit_count1),
        .best_nonce(best_nonce1), .min_hash(min_hash1),
        .mem_clk(mem_clk1), .mem_we(mem_we1), .memory_addr(memory_addr1),
        .memory_write_data(memory_write_data1), .memory_read_data(rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with one dead cycle: address seen at edge t, data captured at t+2.
    always @(posedge clk) begin
        rdata0 <= mem0[memory_addr0];
        rdata1 <= mem1[memory_addr1];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && mem_we0) begin
            n_we0++;
            if (q0.size() == 0) begin
                check("unexpected_write0_addr", {16'd0, memory_addr0}, 32'hDEAD_BEEF);
            end else begin
                e = q0.pop_front();
                check("rec0_addr", {16'd0, memory_addr0}, {16'd0, e.addr});
                check("rec0_data", memory_write_data0, e.data);
                check("found0", {31'd0, found0}, {31'd0, e.found});
                check("hit_count0", {27'd0, hit_count0}, e.cnt);
                check("best_nonce0", {16'd0, best_nonce0}, {16'd0, e.best});
                check("min_hash0", min_hash0, e.mn);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && mem_we1) begin
            if (q1.size() == 0) begin
                check("unexpected_write1_addr", {16'd0, memory_addr1}, 32'hDEAD_BEEF);
            end else begin
                e = q1.pop_front();
                check("rec1_addr", {16'd0, memory_addr1}, {16'd0, e.addr});
                check("rec1_data", memory_write_data1, e.data);
                check("found1", {31'd0, found1}, {31'd0, e.found});
                check("hit_count1", {31'd0, hit_count1}, e.cnt);
                check("best_nonce1", {16'd0, best_nonce1}, {16'd0, e.best});
                check("min_hash1", min_hash1, e.mn);
            end
        end
    end

    task automatic push0(input logic [15:0] a, input logic [31:0] d, input logic f,
                         input logic [31:0] c, input logic [15:0] b, input logic [31:0] m);
        exp_t e;
        e.addr = a; e.data = d; e.found = f; e.cnt = c; e.best = b; e.mn = m;
        q0.push_back(e);
    endtask

    task automatic run0(input logic [15:0] base, input logic [15:0] res, input logic [31:0] tgt,
                        input bit pulse_mid, output int cycles);
        @(negedge clk);
        hash_in_addr = base; result_addr = res; target = tgt; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cycles = 0;
        while (!done0 && cycles < 100) begin
            cycles++;
            start0 = (pulse_mid && cycles == 5);
            @(negedge clk);
        end
        start0 = 1'b0;
        check("done0_returned", {31'd0, done0}, 32'd1);
        check("sb0_drained", q0.size(), 32'd0);
    endtask

    initial begin
        int   cyc;
        int   we_before;
        exp_t e1;
        reset_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        hash_in_addr = 16'd0; result_addr = 16'd0; target = 32'd0;
        for (int i = 0; i < 65536; i++) begin
            mem0[i] = 32'd0;
            mem1[i] = 32'd0;
        end
        // i=0 would be 16*0x1000_0000, which overflows 32 bits; use all-ones instead.
        mem0[16'h0100] = 32'hFFFF_FFFF;
        for (int i = 1; i < 16; i++) mem0[16'h0100 + i] = 32'h1000_0000 * (16 - i);
        for (int i = 0; i < 16; i++) mem0[16'h0200 + i] = 32'h0000_0005;
        for (int i = 0; i < 16; i++) mem0[16'h0300 + i] = 32'hFFFF_FFFF;
        mem0[16'h0303] = 32'h0000_0001;
        mem0[16'h0309] = 32'h0000_0001;
        mem1[16'hFFFF] = 32'h0000_0042;
        mem1[16'h0000] = 32'h0000_0001;

        repeat (3) @(negedge clk);
        check("rst_done", {31'd0, done0}, 32'd1);
        check("rst_found", {31'd0, found0}, 32'd0);
        check("rst_hit_count", {27'd0, hit_count0}, 32'd0);
        check("rst_best", {16'd0, best_nonce0}, 32'd0);
        check("rst_min", min_hash0, 32'hFFFF_FFFF);
        check("rst_we", {31'd0, mem_we0}, 32'd0);
        check("rst_addr", {16'd0, memory_addr0}, 32'd0);
        check("rst_wdata", memory_write_data0, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        push0(16'h0A00, 32'h8003_000F, 1'b1, 32'd3, 16'd15, 32'h1000_0000);
        run0(16'h0100, 16'h0A00, 32'h3000_0001, 1'b0, cyc);

        push0(16'h0A01, 32'h0000_000F, 1'b0, 32'd0, 16'd15, 32'h1000_0000);
        run0(16'h0100, 16'h0A01, 32'h0000_0000, 1'b0, cyc);

        push0(16'h0A02, 32'h0000_0000, 1'b0, 32'd0, 16'd0, 32'h0000_0005);
        run0(16'h0200, 16'h0A02, 32'h0000_0005, 1'b0, cyc);

        push0(16'h0A03, 32'h8002_0003, 1'b1, 32'd2, 16'd3, 32'h0000_0001);
        run0(16'h0300, 16'h0A03, 32'hFFFF_FFFF, 1'b0, cyc);

        we_before = n_we0;
        push0(16'h0A04, 32'h8003_000F, 1'b1, 32'd3, 16'd15, 32'h1000_0000);
        run0(16'h0100, 16'h0A04, 32'h3000_0001, 1'b1, cyc);
        check("done_fall_to_rise", cyc, 32'd19);
        check("one_we_pulse", n_we0 - we_before, 32'd1);

        // Abort a scan in READ cycle 8.
        we_before = n_we0;
        @(negedge clk);
        hash_in_addr = 16'h0100; result_addr = 16'h0A05; target = 32'h3000_0001; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_done", {31'd0, done0}, 32'd1);
        check("abort_found", {31'd0, found0}, 32'd0);
        check("abort_hit_count", {27'd0, hit_count0}, 32'd0);
        check("abort_best", {16'd0, best_nonce0}, 32'd0);
        check("abort_min", min_hash0, 32'hFFFF_FFFF);
        check("abort_we", {31'd0, mem_we0}, 32'd0);
        check("abort_addr", {16'd0, memory_addr0}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (25) @(negedge clk);
        check("abort_no_write", n_we0 - we_before, 32'd0);

        push0(16'h0A06, 32'h8003_000F, 1'b1, 32'd3, 16'd15, 32'h1000_0000);
        run0(16'h0100, 16'h0A06, 32'h3000_0001, 1'b0, cyc);

        // Single-nonce instance reading across the address wrap.
        e1.addr = 16'h0B00; e1.data = 32'h8001_0000; e1.found = 1'b1;
        e1.cnt = 32'd1; e1.best = 16'd0; e1.mn = 32'h0000_0042;
        q1.push_back(e1);
        @(negedge clk);
        hash_in_addr = 16'hFFFF; result_addr = 16'h0B00; target = 32'h0000_0100; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("n1_addr_first", {16'd0, memory_addr1}, 32'h0000_FFFF);
        @(negedge clk);
        check("n1_addr_wrap", {16'd0, memory_addr1}, 32'h0000_0000);
        cyc = 0;
        while (!done1 && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        check("done1_returned", {31'd0, done1}, 32'd1);
        check("sb1_drained", q1.size(), 32'd0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
